// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock (in clk cycles) and
// reports lock after consecutive matching periods, plus a sticky timeout.
module clk_div_monitor #(
    parameter int CNT_W      = 16,
    parameter int EXP_PERIOD = 5,
    parameter int TOL        = 0,
    parameter int LOCK_N     = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    input  logic             clr,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             lock,
    output logic             timeout_err
);

    localparam logic [0:0] WAIT_EDGE = 1'b0;
    localparam logic [0:0] RUN       = 1'b1;

    localparam int MW = $clog2(LOCK_N + 1);
    localparam logic [MW-1:0]    LOCK_CNT = MW'(LOCK_N);
    localparam logic [CNT_W:0]   EXP_EXT  = (CNT_W + 1)'(EXP_PERIOD);
    localparam logic [CNT_W:0]   TOL_EXT  = (CNT_W + 1)'(TOL);
    localparam logic [CNT_W-1:0] TO_CNT   = CNT_W'(TIMEOUT);

    logic             s1, s2, s3;
    logic             rise;
    logic [0:0]       state;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic [MW-1:0]    match_cnt;
    logic [CNT_W:0]   diff;
    logic             is_match;
    logic             timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= div_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_comb begin
        rise = s2 & ~s3;
        if ({1'b0, period_cnt} >= EXP_EXT) begin
            diff = {1'b0, period_cnt} - EXP_EXT;
        end else begin
            diff = EXP_EXT - {1'b0, period_cnt};
        end
        is_match    = (diff <= TOL_EXT);
        // A rise on the limit cycle is a valid measurement, not a timeout.
        timeout_hit = (state == RUN) && !rise && (period_cnt == TO_CNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WAIT_EDGE;
            period_cnt  <= '0;
            high_cnt    <= '0;
            period      <= '0;
            high_time   <= '0;
            meas_valid  <= 1'b0;
            match_cnt   <= '0;
            lock        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            lock       <= (match_cnt == LOCK_CNT);
            case (state)
                WAIT_EDGE: begin
                    if (rise) begin
                        state      <= RUN;
                        period_cnt <= CNT_W'(1);
                        high_cnt   <= CNT_W'(1);
                    end else begin
                        period_cnt <= '0;
                        high_cnt   <= '0;
                    end
                end
                RUN: begin
                    if (rise) begin
                        period     <= period_cnt;
                        high_time  <= high_cnt;
                        meas_valid <= 1'b1;
                        period_cnt <= CNT_W'(1);
                        high_cnt   <= CNT_W'(1);
                        if (is_match) begin
                            if (match_cnt != LOCK_CNT) begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end else if (timeout_hit) begin
                        timeout_err <= 1'b1;
                        match_cnt   <= '0;
                        lock        <= 1'b0;
                        state       <= WAIT_EDGE;
                        period_cnt  <= '0;
                        high_cnt    <= '0;
                    end else begin
                        period_cnt <= period_cnt + 1'b1;
                        high_cnt   <= high_cnt + CNT_W'(s2);
                    end
                end
                default: state <= WAIT_EDGE;
            endcase
            // Placed after the FSM so clear overrides match/lock updates,
            // while a coincident timeout keeps the error flag set.
            if (clr) begin
                match_cnt <= '0;
                lock      <= 1'b0;
                if (!timeout_hit) begin
                    timeout_err <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor: two instances (default and a short
// timeout / tolerant variant) share stimulus and are checked against a sample-level model.
module tb_clk_div_monitor;

    localparam int CW    = 16;
    localparam int EXP0  = 5;
    localparam int TOL0  = 0;
    localparam int LOCK0 = 4;
    localparam int TO0   = 1024;
    localparam int EXP1  = 7;
    localparam int TOL1  = 1;
    localparam int LOCK1 = 2;
    localparam int TO1   = 8;

    localparam int EXP_A[2]  = '{EXP0, EXP1};
    localparam int TOL_A[2]  = '{TOL0, TOL1};
    localparam int LOCK_A[2] = '{LOCK0, LOCK1};
    localparam int TO_A[2]   = '{TO0, TO1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic div_in = 1'b0;
    logic clr = 1'b0;

    logic [CW-1:0] per_o[2];
    logic [CW-1:0] hi_o[2];
    logic          mv_o[2];
    logic          lk_o[2];
    logic          te_o[2];

    always #5 clk = ~clk;

    clk_div_monitor #(
        .CNT_W(CW), .EXP_PERIOD(EXP0), .TOL(TOL0), .LOCK_N(LOCK0), .TIMEOUT(TO0)
    ) dut0 (
        .clk(clk), .rst(rst), .div_in(div_in), .clr(clr),
        .period(per_o[0]), .high_time(hi_o[0]), .meas_valid(mv_o[0]),
        .lock(lk_o[0]), .timeout_err(te_o[0])
    );

    clk_div_monitor #(
        .CNT_W(CW), .EXP_PERIOD(EXP1), .TOL(TOL1), .LOCK_N(LOCK1), .TIMEOUT(TO1)
    ) dut1 (
        .clk(clk), .rst(rst), .div_in(div_in), .clr(clr),
        .period(per_o[1]), .high_time(hi_o[1]), .meas_valid(mv_o[1]),
        .lock(lk_o[1]), .timeout_err(te_o[1])
    );

    typedef struct {
        int e;
        int p;
        int h;
        bit lk;
    } meas_t;

    meas_t exp_q[2][$];
    int    set_q[2][$];
    bit    clr_at[int];

    int edge_n   = 0;
    int checks   = 0;
    int failures = 0;

    // model state, indexed by sample number (sample n = div_in at posedge n)
    bit armed[2];
    bit prev[2];
    int last[2];
    int hi[2];
    int streak[2];

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string nm, input int d, input int got, input int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s inst=%0d edge=%0d got=%0d expected=%0d", nm, d, edge_n, got, expv);
        end
    endtask

    task automatic drive(input bit v, input bit r, input bit c);
        int n;
        int p;
        int ad;
        @(negedge clk);
        div_in = v;
        rst    = r;
        clr    = c;
        n = edge_n + 1;
        if (c && !r) clr_at[n] = 1'b1;
        for (int d = 0; d < 2; d++) begin
            if (r) begin
                armed[d]  = 1'b0;
                prev[d]   = 1'b0;
                hi[d]     = 0;
                streak[d] = 0;
            end else begin
                if (c) streak[d] = 0;
                if (v && !prev[d]) begin
                    if (armed[d]) begin
                        p  = n - last[d];
                        ad = (p > EXP_A[d]) ? p - EXP_A[d] : EXP_A[d] - p;
                        if (ad <= TOL_A[d])
                            streak[d] = (streak[d] + 1 > LOCK_A[d]) ? LOCK_A[d] : streak[d] + 1;
                        else
                            streak[d] = 0;
                        exp_q[d].push_back('{n + 2, p, hi[d], streak[d] == LOCK_A[d]});
                    end
                    armed[d] = 1'b1;
                    last[d]  = n;
                    hi[d]    = 0;
                end else if (armed[d] && (n - last[d] == TO_A[d])) begin
                    armed[d]  = 1'b0;
                    streak[d] = 0;
                    set_q[d].push_back(n + 2);
                end
                hi[d]   = hi[d] + int'(v);
                prev[d] = v;
            end
        end
    endtask

    task automatic wave(input int p, input int h, input int cnt);
        repeat (cnt) begin
            repeat (h) drive(1'b1, 1'b0, 1'b0);
            repeat (p - h) drive(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic idle_until(input int target);
        int guard;
        guard = 0;
        while ((edge_n + 1 < target) && (guard < 5000)) begin
            drive(1'b0, 1'b0, 1'b0);
            guard++;
        end
    endtask

    // monitor: compares DUT outputs against the model's expectations
    bit    te_exp[2];
    bit    lk_pend[2];
    bit    lk_exp[2];
    meas_t m;
    bit    tset;

    always begin
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                check("rst_period", d, int'(per_o[d]), 0);
                check("rst_high_time", d, int'(hi_o[d]), 0);
                check("rst_flags", d, int'({mv_o[d], lk_o[d], te_o[d]}), 0);
                exp_q[d].delete();
                set_q[d].delete();
                te_exp[d]  = 1'b0;
                lk_pend[d] = 1'b0;
            end else begin
                tset = 1'b0;
                if (set_q[d].size() > 0 && set_q[d][0] == edge_n) begin
                    void'(set_q[d].pop_front());
                    te_exp[d] = 1'b1;
                    tset      = 1'b1;
                end else if (clr_at.exists(edge_n)) begin
                    te_exp[d] = 1'b0;
                end
                check("timeout_err", d, int'(te_o[d]), int'(te_exp[d]));
                if (tset) check("lock_on_timeout", d, int'(lk_o[d]), 0);
                if (lk_pend[d]) begin
                    check("lock", d, int'(lk_o[d]), int'(lk_exp[d]));
                    lk_pend[d] = 1'b0;
                end
                if (mv_o[d]) begin
                    if (exp_q[d].size() == 0) begin
                        check("unexpected_meas", d, int'(mv_o[d]), 0);
                    end else begin
                        m = exp_q[d].pop_front();
                        check("meas_edge", d, edge_n, m.e);
                        check("period", d, int'(per_o[d]), m.p);
                        check("high_time", d, int'(hi_o[d]), m.h);
                        lk_pend[d] = 1'b1;
                        lk_exp[d]  = m.lk;
                    end
                end else if (exp_q[d].size() > 0 && exp_q[d][0].e < edge_n) begin
                    check("missing_meas", d, int'(mv_o[d]), 1);
                    void'(exp_q[d].pop_front());
                end
            end
        end
    end

    initial begin
        int p;
        int h;
        repeat (3) drive(1'b0, 1'b1, 1'b0);
        wave(5, 3, 12);
        wave(7, 4, 8);
        wave(5, 2, 8);
        wave(8, 4, 6);
        // timeout on inst0, then a clear a few cycles later
        idle_until(last[0] + TO0 + 5);
        drive(1'b0, 1'b0, 1'b1);
        repeat (4) drive(1'b0, 1'b0, 1'b0);
        wave(5, 3, 8);
        // clear lands on the same edge as the timeout
        idle_until(last[0] + TO0 + 2);
        drive(1'b0, 1'b0, 1'b1);
        repeat (5) drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        wave(5, 2, 8);
        // reset mid-period while locked
        repeat (2) drive(1'b1, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        wave(5, 2, 8);
        for (int s = 0; s < 40; s++) begin
            p = int'($urandom_range(2, 12));
            h = int'($urandom_range(1, p - 1));
            wave(p, h, int'($urandom_range(1, 6)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 15)) drive(1'b0, 1'b0, 1'b0);
        end
        repeat (6) drive(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        for (int d = 0; d < 2; d++) check("queue_drained", d, exp_q[d].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
